// File: rtl/cpu_pkg.sv
// Shared types and constants for the 6-bit CPU program loader.
// The loader state encoding lives here so every consumer agrees on it.
package cpu_pkg;

   localparam int unsigned IW             = 17;
   localparam int unsigned AW_DEFAULT     = 3;
   localparam logic [7:0]  BYTE2_MASK     = 8'h01;
   localparam int unsigned BYTES_PER_WORD = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_B0,
      S_B1,
      S_B2,
      S_WRITE,
      S_RUN,
      S_ERR
   } loader_state_e;

endpackage

// File: rtl/program_loader.sv
// Byte-stream loader for the CPU instruction memory: header N, then N
// little-endian 3-byte words, each written through we/wr/wrd, then pc_en.
module program_loader #(
   parameter int unsigned AW = cpu_pkg::AW_DEFAULT,
   parameter int unsigned IW = cpu_pkg::IW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   output logic          we,
   output logic [AW-1:0] wr,
   output logic [IW-1:0] wrd,
   output logic          pc_en,
   output logic          busy,
   output logic          err
);
   import cpu_pkg::*;

   localparam logic [8:0] DEPTH = 9'(2 ** AW);

   loader_state_e state_q;
   logic [IW-1:0] word_q;
   logic [AW-1:0] idx_q;
   logic [AW-1:0] last_q;
   logic          in_ready_q;
   logic          we_q;
   logic [AW-1:0] wr_q;
   logic [IW-1:0] wrd_q;
   logic          pc_en_q;
   logic          busy_q;
   logic          err_q;

   logic byte_fire;
   logic hdr_bad;
   logic b2_bad;

   assign byte_fire = in_valid & in_ready_q;
   assign hdr_bad   = (in_data == 8'd0) || ({1'b0, in_data} > DEPTH);
   assign b2_bad    = |(in_data & ~BYTE2_MASK);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         word_q     <= '0;
         idx_q      <= '0;
         last_q     <= '0;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         wr_q       <= '0;
         wrd_q      <= '0;
         pc_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
               if (start) begin
                  state_q    <= S_HDR;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  pc_en_q    <= 1'b0;
                  err_q      <= 1'b0;
               end
            end
            S_HDR: begin
               if (byte_fire) begin
                  if (hdr_bad) begin
                     state_q    <= S_ERR;
                     in_ready_q <= 1'b0;
                     busy_q     <= 1'b0;
                     err_q      <= 1'b1;
                  end else begin
                     state_q <= S_B0;
                     last_q  <= AW'(in_data - 8'd1);
                     idx_q   <= '0;
                  end
               end
            end
            S_B0, S_B1: begin
               // Bytes enter at the top; the final 1-bit shift in B2 aligns them.
               if (byte_fire) begin
                  word_q  <= {in_data, word_q[IW-1:8]};
                  state_q <= (state_q == S_B0) ? S_B1 : S_B2;
               end
            end
            S_B2: begin
               if (byte_fire) begin
                  in_ready_q <= 1'b0;
                  if (b2_bad) begin
                     state_q <= S_ERR;
                     busy_q  <= 1'b0;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= S_WRITE;
                     word_q  <= {in_data[0], word_q[IW-1:1]};
                     wrd_q   <= {in_data[0], word_q[IW-1:1]};
                     wr_q    <= idx_q;
                     we_q    <= 1'b1;
                  end
               end
            end
            S_WRITE: begin
               we_q <= 1'b0;
               if (idx_q == last_q) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b0;
                  pc_en_q <= 1'b1;
               end else begin
                  state_q    <= S_B0;
                  idx_q      <= idx_q + 1'b1;
                  in_ready_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready = in_ready_q;
   assign we       = we_q;
   assign wr       = wr_q;
   assign wrd      = wrd_q;
   assign pc_en    = pc_en_q;
   assign busy     = busy_q;
   assign err      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: byte streams are turned into the
// expected write list by an arithmetic model and compared with captured writes.
module tb_program_loader;
   import cpu_pkg::*;

   localparam int unsigned AW    = 3;
   localparam int          DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          we;
   logic [AW-1:0] wr;
   logic [IW-1:0] wrd;
   logic          pc_en;
   logic          busy;
   logic          err;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } wr_t;

   wr_t        got_q[$];
   wr_t        exp_q[$];
   logic [7:0] stream[$];
   bit         exp_err;
   bit         exp_pc;
   int         exp_used;
   int         n_chk  = 0;
   int         n_fail = 0;
   int         cyc_cnt = 0;

   always #5 clk = ~clk;

   program_loader #(.AW(AW), .IW(IW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .we       (we),
      .wr       (wr),
      .wrd      (wrd),
      .pc_en    (pc_en),
      .busy     (busy),
      .err      (err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Capture every write pulse; the loader must never be ready while writing.
   always @(negedge clk) begin
      wr_t w;
      if (we) begin
         w.addr = int'(wr);
         w.data = int'(wrd);
         w.cyc  = cyc_cnt;
         got_q.push_back(w);
         chk("ready_low_in_write", 32'(in_ready), 32'd0);
      end
   end

   function automatic void build_model();
      int n;
      int p;
      int b0, b1, b2;
      wr_t w;
      exp_q.delete();
      exp_err  = 1'b0;
      exp_pc   = 1'b0;
      n        = int'(stream[0]);
      exp_used = 1;
      if (n == 0 || n > DEPTH) begin
         exp_err = 1'b1;
         return;
      end
      for (int k = 0; k < n; k++) begin
         p  = 1 + BYTES_PER_WORD * k;
         b0 = int'(stream[p]);
         b1 = int'(stream[p+1]);
         b2 = int'(stream[p+2]);
         exp_used += BYTES_PER_WORD;
         if (b2 > 1) begin
            exp_err = 1'b1;
            return;
         end
         w.addr = k;
         w.data = b2 * 65536 + b1 * 256 + b0;
         w.cyc  = 0;
         exp_q.push_back(w);
      end
      exp_pc = 1'b1;
   endfunction

   task automatic gen_prog(input int n, input int bad);
      logic [7:0] b2;
      stream.delete();
      stream.push_back(8'(n));
      for (int k = 0; k < n; k++) begin
         stream.push_back(8'($urandom));
         stream.push_back(8'($urandom));
         b2 = (k == bad) ? (8'($urandom) | 8'h02) : {7'd0, 1'($urandom)};
         stream.push_back(b2);
      end
   endtask

   task automatic do_start();
      got_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_ready", 32'(in_ready), 32'd1);
      chk("start_err_clr", 32'(err), 32'd0);
      chk("start_pc_clr", 32'(pc_en), 32'd0);
   endtask

   task automatic send_bytes(input int from, input int count, input bit rnd);
      int i = from;
      int guard = 0;
      while (i < count && guard < 4000) begin
         @(negedge clk);
         in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = in_valid ? stream[i] : 8'($urandom);
         if (in_valid && in_ready) i++;
         guard++;
      end
      chk("bytes_accepted", 32'(i), 32'(count));
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic finish_check(input string name, input bit spacing);
      repeat (6) @(negedge clk);
      chk({name, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
         chk({name, "_addr"}, 32'(got_q[k].addr), 32'(exp_q[k].addr));
         chk({name, "_data"}, 32'(got_q[k].data), 32'(exp_q[k].data));
         if (spacing && k > 0)
            chk({name, "_gap"}, 32'(got_q[k].cyc - got_q[k-1].cyc), 32'd4);
      end
      chk({name, "_err"}, 32'(err), 32'(exp_err));
      chk({name, "_pc_en"}, 32'(pc_en), 32'(exp_pc));
      chk({name, "_busy"}, 32'(busy), 32'd0);
      chk({name, "_ready"}, 32'(in_ready), 32'd0);
   endtask

   task automatic run_prog(input string name, input bit rnd);
      build_model();
      do_start();
      send_bytes(0, exp_used, rnd);
      finish_check(name, !rnd);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_we"}, 32'(we), 32'd0);
      chk({tag, "_wr"}, 32'(wr), 32'd0);
      chk({tag, "_wrd"}, 32'(wrd), 32'd0);
      chk({tag, "_pc_en"}, 32'(pc_en), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic chk_four_consts(input string tag);
      int exp4[4];
      exp4 = '{32'h0A050, 32'h0A440, 32'h02080, 32'h10000};
      chk({tag, "_count"}, 32'(got_q.size()), 32'd4);
      for (int k = 0; k < 4 && k < got_q.size(); k++)
         chk({tag, "_word"}, 32'(got_q[k].data), 32'(exp4[k]));
   endtask

   task automatic load_four();
      stream = '{8'h04, 8'h50, 8'hA0, 8'h00, 8'h40, 8'hA4, 8'h00,
                 8'h80, 8'h20, 8'h00, 8'h00, 8'h00, 8'h01};
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      load_four();
      run_prog("four", 1'b0);
      chk_four_consts("four_const");

      stream = '{8'h00};
      run_prog("hdr0", 1'b0);
      stream = '{8'h09};
      run_prog("hdr9", 1'b0);

      gen_prog(8, -1);
      run_prog("full8", 1'b0);

      stream = '{8'h02, 8'h11, 8'h22, 8'h03, 8'h33, 8'h44, 8'h00};
      run_prog("bad_b2", 1'b0);

      load_four();
      run_prog("four_rndvalid", 1'b1);
      chk_four_consts("rnd_const");

      for (int t = 0; t < 6; t++) begin
         int n;
         int bad;
         n   = int'($urandom_range(1, DEPTH));
         bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         gen_prog(n, bad);
         run_prog("random", 1'($urandom_range(0, 1)));
      end

      // Reset while waiting for byte1 of word 2.
      load_four();
      build_model();
      do_start();
      send_bytes(0, 5, 1'b0);
      repeat (2) @(negedge clk);
      chk("midrst_pre_writes", 32'(got_q.size()), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_zero("midrst");
      repeat (8) @(negedge clk);
      chk("midrst_no_more_we", 32'(got_q.size()), 32'd1);
      load_four();
      run_prog("after_rst", 1'b0);

      // A start pulse while stalled in B0 must be ignored.
      gen_prog(3, -1);
      build_model();
      do_start();
      send_bytes(0, 1, 1'b0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("b0_start_busy", 32'(busy), 32'd1);
      chk("b0_start_ready", 32'(in_ready), 32'd1);
      send_bytes(1, exp_used, 1'b0);
      finish_check("b0_start", 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/program_loader.md
# program_loader

Front-end writer for the 6-bit CPU's instruction memory. It accepts a byte stream with valid/ready handshaking, assembles 17-bit instruction words, and drives the CPU's `we`/`wr`/`wrd` write port one word at a time. After the last word is written it asserts `pc_en` so the CPU starts executing. It sits between a byte source (UART receiver, host FIFO or bench) and the CPU's load inputs. It replaces hand-driven loading of the instruction memory.

## Interface
Parameters:
- `AW`, default 3: instruction-memory address width; depth is 2^AW.
- `IW`, default 17: instruction word width. Fixed at 17 for this CPU; it is a parameter only for documentation.

Ports:
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: reset, synchronous, active-high.
- `start` input, 1: single-cycle pulse that begins a load session.
- `in_valid` input, 1: byte source has data.
- `in_data` input, 8: stream byte.
- `in_ready` output, 1: loader accepts a byte this cycle.
- `we` output, 1: memory write enable to the CPU.
- `wr` output, AW: write address to the CPU.
- `wrd` output, IW: write data to the CPU.
- `pc_en` output, 1: CPU program-counter enable.
- `busy` output, 1: a load session is in progress.
- `err` output, 1: the session aborted on a format error.

## Operation
Stream format:
- Header byte `N` gives the instruction count. Legal values are 1..2^AW.
- Then N words follow, each sent as 3 bytes, little-endian.
- Byte0 supplies `wrd[7:0]`, byte1 supplies `wrd[15:8]`, byte2 bit0 supplies `wrd[16]`.
- Byte2 bits [7:1] must be 0.

A byte transfers on a rising edge where `in_valid & in_ready` is 1.

States:
- IDLE: `in_ready`=0. `start` goes to HDR and clears `pc_en` and `err`.
- HDR: `in_ready`=1. Accepting N=0 or N>2^AW goes to ERR. Otherwise latch N, set idx=0 and go to B0.
- B0 / B1 / B2: `in_ready`=1. Each accepted byte shifts into the word register and the state advances. In B2, nonzero bits [7:1] go to ERR; otherwise go to WRITE.
- WRITE: one cycle with `in_ready`=0, `we`=1, `wr`=idx, `wrd`=assembled word. Then, if idx==N-1, go to RUN; else increment idx and go to B0.
- RUN: `pc_en`=1, `busy`=0. Stays here until `start` arrives, which clears `pc_en` and goes to HDR for a reload.
- ERR: `err`=1, `pc_en`=0, `busy`=0. `start` goes to HDR.

Rules:
- `busy`=1 in HDR, B0, B1, B2 and WRITE.
- `start` is ignored while `busy`=1.
- The word register is not cleared between words. Every word is fully overwritten by its three bytes.
- Addresses always run 0..N-1. idx never wraps, because N ≤ 2^AW.
- `wr` and `wrd` hold their last values when `we`=0. Consumers qualify them with `we`.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, `in_ready`=0, `we`=0, `wr`=0, `wrd`=0, `pc_en`=0, `busy`=0, `err`=0.
- `start` sampled at edge t gives `in_ready`=1 and `busy`=1 from edge t+1.
- The edge that accepts byte2 makes `we`=1 for exactly the next cycle.
- The first byte of the next word can be accepted no earlier than the edge that ends the WRITE cycle.
- Throughput: 4 cycles per word when `in_valid` is held at 1.
- `pc_en` rises on the edge that ends the last WRITE cycle.
- `in_valid` low stalls any byte state indefinitely. There is no timeout.
- `rst` mid-session: the next edge returns everything to reset values. No further `we` is issued. Words already written remain in CPU memory.
- `rst` and `start` in the same cycle: `rst` wins.

## Structure
- Package `cpu_pkg` holds the state enum, `IW`=17, the default `AW`, and localparams for the byte-2 legal mask (8'h01) and bytes per word (3).
- Single flat module with no sub-modules.
- The byte/word assembler is a 17-bit shift register inside this module.

## Test plan
- Four-word program: header 8'h04, then 50 A0 00, 40 A4 00, 80 20 00, 00 00 01, all with `in_valid` held at 1.
  - Required `we` pulses: wr=0 wrd=17'h0A050, wr=1 wrd=17'h0A440, wr=2 wrd=17'h02080, wr=3 wrd=17'h10000.
  - `pc_en`=1 after the 4th pulse.
  - 4 cycles between consecutive `we` pulses.
- Header 8'h00 → `err`=1, no `we` pulse, `pc_en`=0. A following `start` → `busy`=1, `err`=0.
- Header 8'h09 → `err`. Header 8'h08 with 8 words → addresses 0..7 written in order, no wrap.
- Byte2=8'h03 on the first word → `err`=1 and no `we` pulse for that word.
- `in_valid` toggled randomly → identical write sequence to the first scenario, and no byte accepted while `in_ready`=0.
- `rst` asserted in B1 of word 2 → next cycle all outputs 0; a subsequent `start` plus a full stream loads correctly. `start` pulsed during B0 → ignored.
